// File: rtl/imem_pkg.sv
// imem_pkg: shared state type and instruction-word constants for the instruction memory responder.
package imem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int INSTR_W = 32;
    localparam int WORD_OFF = 2;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH_WORDS x 32 storage with one synchronous read port and one synchronous write port.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               rd_en,
    input  logic               rd_clr,
    input  logic [AW-1:0]      rd_idx,
    output logic [INSTR_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_idx,
    input  logic [INSTR_W-1:0] wr_data
);
    logic [INSTR_W-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk)
        if (wr_en) mem[wr_idx] <= wr_data;
    // Read and write share an edge; the non-blocking update gives read-before-write.
    always_ff @(posedge clk)
        if (rd_clr) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_idx];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction fetch responder with fixed wait states
// and a preload write port into the instruction store.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_error,
    input  logic               prog_we,
    input  logic [31:0]        prog_addr,
    input  logic [INSTR_W-1:0] prog_data
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [31:0] addr_q, addr_n, rd_addr;
    logic err_q, enter, rd_bad, wr_ok;

    function automatic logic bad_addr(input logic [31:0] a);
        return a[WORD_OFF-1:0] != '0 || {2'b0, a[31:WORD_OFF]} >= 32'(DEPTH_WORDS);
    endfunction

    always_ff @(posedge clk)
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            addr_q <= addr_n;
            if (enter) err_q <= rd_bad;
        end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        addr_n = addr_q;
        case (state)
            IDLE: if (req_valid) begin
                addr_n = req_addr;
                state_n = LATENCY == 0 ? RESP : WAIT;
                cnt_n = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
            end
            WAIT: begin
                state_n = cnt == '0 ? RESP : WAIT;
                cnt_n = cnt == '0 ? cnt : cnt - 4'd1;
            end
            RESP: state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // With zero wait states the read happens on the accepting edge, before the address is latched.
    assign rd_addr = state == IDLE ? req_addr : addr_q;
    assign enter = reset && state != RESP && state_n == RESP;
    assign rd_bad = bad_addr(rd_addr);
    assign wr_ok = reset && prog_we && !bad_addr(prog_addr);

    imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk(clk),
        .rd_en(enter),
        .rd_clr(!reset || (enter && rd_bad)),
        .rd_idx(rd_addr[WORD_OFF +: AW]),
        .rd_data(rsp_instr),
        .wr_en(wr_ok),
        .wr_idx(prog_addr[WORD_OFF +: AW]),
        .wr_data(prog_data)
    );

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_error = err_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: table-driven, directed and randomized checks of imem_responder
// (LATENCY=2 instance plus a LATENCY=0 instance sharing the same inputs).
module tb_imem_responder;
    localparam int LAT = 2;
    localparam int DEPTH = 256;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          hold;
    } vec_t;

    logic clk = 0, reset = 0, req_valid = 0, rsp_ready = 0, prog_we = 0;
    logic [31:0] req_addr = 0, prog_addr = 0, prog_data = 0;
    logic req_ready, rsp_valid, rsp_error, z_req_ready, z_rsp_valid, z_rsp_error;
    logic [31:0] rsp_instr, z_rsp_instr;
    int n_cmp = 0, n_fail = 0;
    logic [31:0] mem_m [DEPTH];
    vec_t vt[6];
    logic [31:0] z_exp[3];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_error(rsp_error), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data)
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dz (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(z_req_ready),
        .req_addr(req_addr), .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(z_rsp_instr), .rsp_error(z_rsp_error), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a);
        if (a % 4 != 0 || a / 4 >= DEPTH) return {1'b1, 32'h0};
        return {1'b0, mem_m[int'(a >> 2)]};
    endfunction

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1;
        prog_addr = a;
        prog_data = d;
        tick;
        prog_we = 0;
        if (a % 4 == 0 && a / 4 < DEPTH) mem_m[int'(a >> 2)] = d;
    endtask

    task automatic fetch(input string nm, input logic [31:0] a, input logic [31:0] ei,
                         input logic ee, input int hold);
        int n;
        logic [31:0] i0;
        logic e0;
        chk({nm, "/req_ready"}, 32'(req_ready), 1);
        req_valid = 1;
        req_addr = a;
        rsp_ready = 0;
        tick;
        req_valid = 0;
        req_addr = $urandom;
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick;
            n++;
        end
        chk({nm, "/latency"}, n, LAT + 1);
        chk({nm, "/instr"}, rsp_instr, ei);
        chk({nm, "/error"}, 32'(rsp_error), 32'(ee));
        i0 = rsp_instr;
        e0 = rsp_error;
        for (int k = 0; k < hold; k++) begin
            req_addr = $urandom;
            tick;
            chk({nm, "/hold_valid"}, 32'(rsp_valid), 1);
            chk({nm, "/hold_instr"}, rsp_instr, i0);
            chk({nm, "/hold_error"}, 32'(rsp_error), 32'(e0));
            chk({nm, "/hold_req_ready"}, 32'(req_ready), 0);
        end
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
        chk({nm, "/post_valid"}, 32'(rsp_valid), 0);
        chk({nm, "/post_req_ready"}, 32'(req_ready), 1);
    endtask

    initial begin
        vt[0] = '{addr: 32'h4,   instr: 32'h8C220004, err: 1'b0, hold: 0};
        vt[1] = '{addr: 32'h6,   instr: 32'h0,        err: 1'b1, hold: 0};
        vt[2] = '{addr: 32'h400, instr: 32'h0,        err: 1'b1, hold: 2};
        vt[3] = '{addr: 32'h3FC, instr: 32'hCAFEF00D, err: 1'b0, hold: 1};
        vt[4] = '{addr: 32'h4,   instr: 32'h8C220004, err: 1'b0, hold: 5};
        vt[5] = '{addr: 32'h8,   instr: 32'h10000022, err: 1'b0, hold: 0};
        z_exp[0] = 32'h10000000;
        z_exp[1] = 32'h8C220004;
        z_exp[2] = 32'h10000022;

        tick;
        tick;
        chk("reset/rsp_valid", 32'(rsp_valid), 0);
        chk("reset/rsp_instr", rsp_instr, 0);
        chk("reset/rsp_error", 32'(rsp_error), 0);
        chk("reset/req_ready", 32'(req_ready), 1);
        reset = 1;
        tick;
        chk("reset/req_ready_after", 32'(req_ready), 1);

        for (int i = 0; i < DEPTH; i++) prog(32'(i * 4), 32'h10000000 + 32'(i) * 32'h11);
        prog(32'h4, 32'h8C220004);
        prog(32'h3FC, 32'hCAFEF00D);
        prog(32'h9, 32'hBADBAD00);
        prog(32'h800, 32'hBADBAD01);

        for (int i = 0; i < 6; i++)
            fetch($sformatf("vec%0d", i), vt[i].addr, vt[i].instr, vt[i].err, vt[i].hold);

        // Preload write to the word being read on the RESP-entry edge.
        req_valid = 1;
        req_addr = 32'h14;
        tick;
        req_valid = 0;
        tick;
        prog_we = 1;
        prog_addr = 32'h14;
        prog_data = 32'hDEADBEEF;
        tick;
        prog_we = 0;
        mem_m[5] = 32'hDEADBEEF;
        chk("collide/valid", 32'(rsp_valid), 1);
        chk("collide/old_instr", rsp_instr, 32'h10000055);
        chk("collide/error", 32'(rsp_error), 0);
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
        fetch("refetch", 32'h14, 32'hDEADBEEF, 1'b0, 0);

        // Reset pulse mid-WAIT, with a preload write that must be ignored.
        req_valid = 1;
        req_addr = 32'h4;
        tick;
        req_valid = 0;
        tick;
        reset = 0;
        prog_we = 1;
        prog_addr = 32'h4;
        prog_data = 32'h0BAD0BAD;
        tick;
        reset = 1;
        prog_we = 0;
        chk("wait_rst/rsp_valid", 32'(rsp_valid), 0);
        chk("wait_rst/req_ready", 32'(req_ready), 1);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("wait_rst/no_rsp", 32'(rsp_valid), 0);
        end
        fetch("after_rst", 32'h4, 32'h8C220004, 1'b0, 0);

        // Zero-latency back-to-back fetches.
        reset = 0;
        tick;
        reset = 1;
        rsp_ready = 1;
        req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(i * 4);
            tick;
            chk($sformatf("lat0_%0d/valid", i), 32'(z_rsp_valid), 1);
            chk($sformatf("lat0_%0d/instr", i), z_rsp_instr, z_exp[i]);
            chk($sformatf("lat0_%0d/error", i), 32'(z_rsp_error), 0);
            tick;
            chk($sformatf("lat0_%0d/idle_valid", i), 32'(z_rsp_valid), 0);
            chk($sformatf("lat0_%0d/idle_ready", i), 32'(z_req_ready), 1);
        end
        req_valid = 0;
        for (int k = 0; k < 5; k++) tick;
        rsp_ready = 0;
        reset = 0;
        tick;
        reset = 1;
        tick;

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [32:0] e;
            if ($urandom_range(0, 1) == 1) begin
                a = 32'($urandom_range(0, 1100));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                prog(a, $urandom);
            end
            a = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            e = model(a);
            fetch($sformatf("rnd%0d", i), a, e[31:0], e[32], $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
